pll_lock_monitor: RTL and testbench
===================================

Name: pll_lock_monitor

Overview:
- Parametrised successor to the existing single-source CDR/PLL lock filter/detector.
- Filters one of NSRC instant-lock indications into a debounced PLL-locked status, with lock, relock and unlock hysteresis.
- Keeps a saturating, clearable loss-of-lock counter and emits a one-cycle unlock event pulse.
- Sits between the PLL/CDR instant-lock outputs and the global controller; its locked output feeds the power-sequence state machine and the pllUnlockCount register.

Parameters:
- NSRC, 2, number of instant-lock sources (≥1).
- SELW, 1, width of the source select; equals max(1, clog2(NSRC)).
- THR_W, 4, width of each threshold and of the internal run counters.
- CNT_W, 8, width of the loss-of-lock counter.
- SYNC_STAGES, 2, synchroniser flops on each instLockIn bit; 0 means no synchroniser.

Ports:
- clk40  input  1  state-machine clock.
- rstn  input  1  asynchronous active-low reset.
- instLockIn  input  NSRC  raw instant-lock indications, possibly asynchronous.
- sel  input  SELW  source select; a value ≥NSRC selects source 0.
- lockThr  input  THR_W  consecutive good cycles needed to go UNLOCKED→LOCKED.
- relockThr  input  THR_W  consecutive good cycles needed to go CHECK→LOCKED.
- unlockThr  input  THR_W  cumulative bad cycles needed to go CHECK→UNLOCKED.
- clrCount  input  1  synchronous clear of lossOfLockCount.
- state  output  2  0=UNLOCKED, 1=LOCKED, 2=CHECK (3 is unused).
- instantLock  output  1  registered, synchronised selected source.
- locked  output  1  filtered lock status.
- lossOfLockCount  output  CNT_W  saturating count of lock losses.
- unlockPulse  output  1  one-cycle pulse on each LOCKED/CHECK→UNLOCKED transition.

Behaviour:
- Reset (rstn=0, asynchronous): state=UNLOCKED, locked=0, instantLock=0, unlockPulse=0, lossOfLockCount=0. Synchroniser flops, run counters and selReg are all cleared.
- Input path: each instLockIn bit passes through SYNC_STAGES flops. The mux output is registered into instantLock. Latency from instLockIn to instantLock is SYNC_STAGES+1 clk40 edges.
- Effective threshold: thrEff = (thr==0) ? 1 : thr, applied to each of the three thresholds.
- All comparisons use ≥. Threshold inputs are quasi-static but are compared live; lowering a threshold below the current count causes the transition on the next edge.
- Run counters are THR_W wide and saturate at all-ones.
- A change of sel (detected against registered selReg) clears both run counters on that edge. State is held.
- UNLOCKED:
  - goodCnt increments when instantLock=1 and clears when instantLock=0.
  - When instantLock=1 and goodCnt+1 ≥ thrEff(lockThr): next state=LOCKED, locked=1 on the same edge, counters cleared.
  - Consequently, with lockThr=N, locked rises N edges after instantLock first samples high.
- LOCKED:
  - instantLock=0 → next state=CHECK, badCnt=1, goodCnt=0.
  - locked stays 1.
- CHECK:
  - instantLock=1: goodCnt increments. When goodCnt+1 ≥ thrEff(relockThr) → LOCKED, both counters cleared.
  - instantLock=0: goodCnt clears and badCnt increments; badCnt is not cleared by good cycles. When badCnt+1 ≥ thrEff(unlockThr) → UNLOCKED, with locked=0, unlockPulse=1 for exactly one cycle, and lossOfLockCount incremented.
  - locked stays 1 throughout CHECK.
- Both CHECK conditions are evaluated each cycle on the current instantLock, so they are mutually exclusive.
- lossOfLockCount:
  - Saturates at 2^CNT_W−1 and never wraps.
  - clrCount=1 alone sets it to 0.
  - clrCount together with a loss event on the same edge sets it to 1.
- State encoding 3 is never reached. If it is entered, the next edge goes to UNLOCKED without a pulse or count increment.
- Reset asserted mid-CHECK: all outputs return to reset values immediately. No unlockPulse is emitted.

Decomposition:
- Shared package pll_lock_pkg holds:
  - the state encoding constants UNLOCKED/LOCKED/CHECK, shared with globalController and its status registers;
  - the default threshold constant (4'd8).
- One natural sub-module: bit_synchronizer, with SYNC_STAGES depth, async active-low reset and reset value 0. It is instantiated NSRC wide.

Test Plan:
- Power-up lock: NSRC=2, sel=1, thresholds all 8, SYNC_STAGES=2; rstn released, instLockIn[1]=1 steady → instantLock high after 3 edges, locked high 8 edges later, state=1, lossOfLockCount=0.
- Glitch tolerance: from LOCKED, 3 low cycles then high → state=2 for the glitch; after 8 good cycles state=1. locked stays 1, no unlockPulse, count stays 0.
- Intermittent loss: from LOCKED, alternating 1-low/1-high pattern → badCnt accumulates; after 8 bad cycles state=0, locked=0, one unlockPulse, lossOfLockCount=1.
- Saturation and clear: CNT_W=2, force 5 lock/unlock cycles → count stops at 3. clrCount coincident with the 6th loss → count=1. clrCount alone → 0.
- Threshold 0 and source switch: lockThr=0 → locked 1 edge after instantLock rises. Switching sel while in CHECK clears counters with state held; sel=3 with NSRC=2 uses source 0.
- Async reset mid-CHECK: rstn pulsed low between edges → outputs zero immediately, no unlockPulse, relock needs the full lockThr.

Source files
------------

// File: rtl/pll_lock_pkg.sv
// Shared lock-monitor definitions: state encoding (also used by globalController
// status registers) and the default filter threshold.
package pll_lock_pkg;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED   = 2'd1,
        CHECK    = 2'd2,
        ILLEGAL  = 2'd3
    } lockState_t;

    localparam logic [3:0] DEFAULT_THR = 4'd8;

endpackage

// File: rtl/bit_synchronizer.sv
// Single-bit synchroniser chain, STAGES flops deep, async active-low reset to 0.
// STAGES == 0 degenerates to a wire for already-synchronous sources.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    if (STAGES == 0) begin : gNoSync
        assign q = d;
    end else begin : gSync
        logic [STAGES-1:0] ff;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                ff <= '0;
            end else begin
                ff[0] <= d;
                for (int i = 1; i < STAGES; i++) ff[i] <= ff[i-1];
            end
        end

        assign q = ff[STAGES-1];
    end

endmodule

// File: rtl/pll_lock_monitor.sv
// Debounced PLL lock status with lock/relock/unlock hysteresis, selectable
// instant-lock source, saturating loss-of-lock counter and unlock event pulse.
module pll_lock_monitor
    import pll_lock_pkg::*;
#(
    parameter int NSRC        = 2,
    parameter int SELW        = 1,
    parameter int THR_W       = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk40,
    input  logic             rstn,
    input  logic [NSRC-1:0]  instLockIn,
    input  logic [SELW-1:0]  sel,
    input  logic [THR_W-1:0] lockThr,
    input  logic [THR_W-1:0] relockThr,
    input  logic [THR_W-1:0] unlockThr,
    input  logic             clrCount,
    output logic [1:0]       state,
    output logic             instantLock,
    output logic             locked,
    output logic [CNT_W-1:0] lossOfLockCount,
    output logic             unlockPulse
);

    lockState_t       stateReg, stateNext;
    logic [NSRC-1:0]  syncLock;
    logic [SELW-1:0]  selEff, selReg;
    logic             selBit, selChanged, lossEvent;
    logic [THR_W-1:0] goodCnt, badCnt, goodNext, badNext, goodSat, badSat;
    logic [THR_W:0]   goodInc, badInc;

    // Zero threshold behaves as one so a transition always needs at least one sample.
    function automatic logic [THR_W:0] thrEff(input logic [THR_W-1:0] thr);
        return (thr == '0) ? (THR_W+1)'(1) : {1'b0, thr};
    endfunction

    bit_synchronizer #(.STAGES(SYNC_STAGES)) uSync [NSRC-1:0] (
        .clk  (clk40),
        .rstn (rstn),
        .d    (instLockIn),
        .q    (syncLock)
    );

    assign selEff = (int'(sel) >= NSRC) ? '0 : sel;

    always_comb begin
        selBit = 1'b0;
        for (int i = 0; i < NSRC; i++)
            if (selEff == SELW'(i)) selBit = syncLock[i];
    end

    always_ff @(posedge clk40 or negedge rstn) begin
        if (!rstn) begin
            instantLock <= 1'b0;
            selReg      <= '0;
        end else begin
            instantLock <= selBit;
            selReg      <= sel;
        end
    end

    assign selChanged = (sel != selReg);
    assign goodInc    = {1'b0, goodCnt} + (THR_W+1)'(1);
    assign badInc     = {1'b0, badCnt} + (THR_W+1)'(1);
    assign goodSat    = (&goodCnt) ? goodCnt : goodCnt + THR_W'(1);
    assign badSat     = (&badCnt) ? badCnt : badCnt + THR_W'(1);

    // State register
    always_ff @(posedge clk40 or negedge rstn) begin
        if (!rstn) stateReg <= UNLOCKED;
        else       stateReg <= stateNext;
    end

    // Next-state and run-counter update
    always_comb begin
        stateNext = stateReg;
        goodNext  = goodCnt;
        badNext   = badCnt;
        lossEvent = 1'b0;
        if (selChanged) begin
            goodNext = '0;
            badNext  = '0;
        end else begin
            case (stateReg)
                UNLOCKED: begin
                    badNext = '0;
                    if (!instantLock) begin
                        goodNext = '0;
                    end else if (goodInc >= thrEff(lockThr)) begin
                        stateNext = LOCKED;
                        goodNext  = '0;
                    end else begin
                        goodNext = goodSat;
                    end
                end
                LOCKED: begin
                    goodNext = '0;
                    badNext  = '0;
                    if (!instantLock) begin
                        stateNext = CHECK;
                        badNext   = THR_W'(1);
                    end
                end
                CHECK: begin
                    if (instantLock) begin
                        if (goodInc >= thrEff(relockThr)) begin
                            stateNext = LOCKED;
                            goodNext  = '0;
                            badNext   = '0;
                        end else begin
                            goodNext = goodSat;
                        end
                    end else begin
                        // Bad cycles accumulate across good runs; only relock clears them.
                        goodNext = '0;
                        if (badInc >= thrEff(unlockThr)) begin
                            stateNext = UNLOCKED;
                            badNext   = '0;
                            lossEvent = 1'b1;
                        end else begin
                            badNext = badSat;
                        end
                    end
                end
                default: begin
                    stateNext = UNLOCKED;
                    goodNext  = '0;
                    badNext   = '0;
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        locked = (stateReg == LOCKED) || (stateReg == CHECK);
        state  = stateReg;
    end

    always_ff @(posedge clk40 or negedge rstn) begin
        if (!rstn) begin
            goodCnt         <= '0;
            badCnt          <= '0;
            unlockPulse     <= 1'b0;
            lossOfLockCount <= '0;
        end else begin
            goodCnt     <= goodNext;
            badCnt      <= badNext;
            unlockPulse <= lossEvent;
            if (clrCount)
                lossOfLockCount <= lossEvent ? CNT_W'(1) : '0;
            else if (lossEvent && !(&lossOfLockCount))
                lossOfLockCount <= lossOfLockCount + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pll_lock_monitor.sv
// Scenario bench for pll_lock_monitor: per-edge expectations are queued with the
// stimulus and popped after each edge; unlock pulses are tallied independently.
module tb_pll_lock_monitor;

    localparam int NSRC = 2, SELW = 2, THR_W = 4, CNT_W = 2, SYNC_STAGES = 2;

    typedef struct packed {
        logic [1:0] st;
        logic       lk;
        logic       il;
        logic       pu;
        logic [1:0] cnt;
    } obs_t;

    logic             clk40 = 1'b0;
    logic             rstn;
    logic [NSRC-1:0]  instLockIn;
    logic [SELW-1:0]  sel;
    logic [THR_W-1:0] lockThr, relockThr, unlockThr;
    logic             clrCount;
    logic [1:0]       state;
    logic             instantLock, locked, unlockPulse;
    logic [CNT_W-1:0] lossOfLockCount;

    int   checks = 0;
    int   errors = 0;
    int   expPulses = 0;
    int   seenPulses = 0;
    obs_t expQ[$];
    obs_t cur, e;

    pll_lock_monitor #(
        .NSRC(NSRC), .SELW(SELW), .THR_W(THR_W), .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk40(clk40), .rstn(rstn), .instLockIn(instLockIn), .sel(sel),
        .lockThr(lockThr), .relockThr(relockThr), .unlockThr(unlockThr),
        .clrCount(clrCount), .state(state), .instantLock(instantLock),
        .locked(locked), .lossOfLockCount(lossOfLockCount), .unlockPulse(unlockPulse)
    );

    always #5 clk40 = ~clk40;

    assign cur = '{state, locked, instantLock, unlockPulse, lossOfLockCount};

    always @(negedge clk40) if (unlockPulse === 1'b1) seenPulses++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk40);
            #1;
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0; instLockIn = '0; sel = 2'd1; clrCount = 1'b0;
        lockThr = 4'd8; relockThr = 4'd8; unlockThr = 4'd8;
        tick(3);
        checks++;
        if (cur !== obs_t'(0)) begin
            errors++; $display("FAIL reset: got %p want all zero", cur);
        end
    endtask

    task automatic test_power_up_lock;
        rstn = 1'b1; instLockIn = 2'b10;
        for (int k = 1; k <= 12; k++) begin
            expQ.push_back('{(k >= 11) ? 2'd1 : 2'd0, k >= 11, k >= 3, 1'b0, 2'd0});
            tick();
            e = expQ.pop_front();
            checks++;
            if (cur !== e) begin
                errors++; $display("FAIL power_up k=%0d: got %p want %p", k, cur, e);
            end
        end
    endtask

    task automatic test_glitch;
        for (int k = 1; k <= 16; k++) begin
            instLockIn = (k <= 3) ? 2'b00 : 2'b10;
            expQ.push_back('{(k >= 4 && k <= 13) ? 2'd2 : 2'd1, 1'b1,
                             !(k >= 3 && k <= 5), 1'b0, 2'd0});
            tick();
            e = expQ.pop_front();
            checks++;
            if (cur !== e) begin
                errors++; $display("FAIL glitch k=%0d: got %p want %p", k, cur, e);
            end
        end
    endtask

    task automatic test_intermittent;
        for (int k = 1; k <= 20; k++) begin
            instLockIn = (k % 2 == 1) ? 2'b00 : 2'b10;
            expQ.push_back('{(k < 4) ? 2'd1 : (k < 18) ? 2'd2 : 2'd0, k < 18,
                             (k < 3) ? 1'b1 : (k % 2 == 0), k == 18,
                             (k >= 18) ? 2'd1 : 2'd0});
            tick();
            e = expQ.pop_front();
            checks++;
            if (cur !== e) begin
                errors++; $display("FAIL intermittent k=%0d: got %p want %p", k, cur, e);
            end
        end
        expPulses++;
        instLockIn = 2'b00;
    endtask

    task automatic test_saturation_clear;
        tick(4);
        lockThr = 4'd1; relockThr = 4'd1; unlockThr = 4'd1;
        for (int c = 0; c < 5; c++) begin
            instLockIn = 2'b10; tick(6);
            instLockIn = 2'b00;
            expQ.push_back('{2'd0, 1'b0, 1'b0, 1'b0, (c >= 1) ? 2'd3 : 2'd2});
            tick(6);
            expPulses++;
            e = expQ.pop_front();
            checks++;
            if (cur !== e) begin
                errors++; $display("FAIL saturate cycle=%0d: got %p want %p", c, cur, e);
            end
        end
        instLockIn = 2'b10; tick(6);
        instLockIn = 2'b00; tick(4);
        checks++;
        if (state !== 2'd2) begin
            errors++; $display("FAIL clr_loss_setup: state got %0d want 2", state);
        end
        clrCount = 1'b1; tick(); clrCount = 1'b0;
        expPulses++;
        checks++;
        if (cur !== obs_t'{2'd0, 1'b0, 1'b0, 1'b1, 2'd1}) begin
            errors++; $display("FAIL clr_with_loss: got %p want st=0 pu=1 cnt=1", cur);
        end
        tick();
        checks++;
        if (unlockPulse !== 1'b0 || lossOfLockCount !== 2'd1) begin
            errors++; $display("FAIL pulse_one_cycle: pulse=%0b cnt=%0d want 0/1", unlockPulse, lossOfLockCount);
        end
        clrCount = 1'b1; tick(); clrCount = 1'b0;
        checks++;
        if (lossOfLockCount !== 2'd0) begin
            errors++; $display("FAIL clr_alone: cnt got %0d want 0", lossOfLockCount);
        end
    endtask

    task automatic test_thr0_and_switch;
        lockThr = 4'd0; relockThr = 4'd8; unlockThr = 4'd8; sel = 2'd1;
        instLockIn = 2'b10; tick(3);
        checks++;
        if (instantLock !== 1'b1 || locked !== 1'b0) begin
            errors++; $display("FAIL thr0_pre: il=%0b locked=%0b want 1/0", instantLock, locked);
        end
        tick();
        checks++;
        if (locked !== 1'b1 || state !== 2'd1) begin
            errors++; $display("FAIL thr0_lock: locked=%0b state=%0d want 1/1", locked, state);
        end
        instLockIn = 2'b00; tick(4);
        checks++;
        if (state !== 2'd2) begin
            errors++; $display("FAIL switch_check: state got %0d want 2", state);
        end
        tick(2);
        sel = 2'd0;
        for (int k = 7; k <= 15; k++) begin
            expQ.push_back('{(k <= 14) ? 2'd2 : 2'd0, k <= 14, 1'b0, k == 15,
                             (k == 15) ? 2'd1 : 2'd0});
            tick();
            e = expQ.pop_front();
            checks++;
            if (cur !== e) begin
                errors++; $display("FAIL sel_switch k=%0d: got %p want %p", k, cur, e);
            end
        end
        expPulses++;
        sel = 2'd3; instLockIn = 2'b01; tick(3);
        checks++;
        if (instantLock !== 1'b1 || state !== 2'd0) begin
            errors++; $display("FAIL sel_oob_il: il=%0b state=%0d want 1/0", instantLock, state);
        end
        tick();
        checks++;
        if (state !== 2'd1 || locked !== 1'b1) begin
            errors++; $display("FAIL sel_oob_lock: state=%0d locked=%0b want 1/1", state, locked);
        end
    endtask

    task automatic test_async_reset;
        lockThr = 4'd8; relockThr = 4'd8; unlockThr = 4'd8;
        instLockIn = 2'b00; tick(4);
        checks++;
        if (state !== 2'd2) begin
            errors++; $display("FAIL async_setup: state got %0d want 2", state);
        end
        #3 rstn = 1'b0;
        #1;
        checks++;
        if (cur !== obs_t'(0)) begin
            errors++; $display("FAIL async_reset: got %p want all zero", cur);
        end
        #1 rstn = 1'b1; instLockIn = 2'b01;
        for (int k = 1; k <= 11; k++) begin
            expQ.push_back('{(k >= 11) ? 2'd1 : 2'd0, k >= 11, k >= 3, 1'b0, 2'd0});
            tick();
            e = expQ.pop_front();
            checks++;
            if (cur !== e) begin
                errors++; $display("FAIL relock_after_reset k=%0d: got %p want %p", k, cur, e);
            end
        end
    endtask

    task automatic test_pulse_total;
        tick(2);
        checks++;
        if (seenPulses !== expPulses) begin
            errors++; $display("FAIL pulse_total: got %0d want %0d", seenPulses, expPulses);
        end
    endtask

    initial begin
        test_reset();
        test_power_up_lock();
        test_glitch();
        test_intermittent();
        test_saturation_clear();
        test_thr0_and_switch();
        test_async_reset();
        test_pulse_total();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
